// File: rtl/display_pkg.sv
// Shared state codes for the DVI link sequencer; debug tooling decodes o_state with these.
package display_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_WAIT_LOCK   = 3'd0,
        ST_WAIT_HPD    = 3'd1,
        ST_RST_HOLD    = 3'd2,
        ST_SYNC_FRAMES = 3'd3,
        ST_ACTIVE      = 3'd4
    } state_t;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser followed by a debouncer that only changes after
// DEBOUNCE_CYCLES consecutive cycles of disagreement.
module sync_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_stable
);

    logic             meta;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta     <= 1'b0;
            o_sync   <= 1'b0;
            o_stable <= 1'b0;
            cnt      <= '0;
        end else begin
            meta   <= i_async;
            o_sync <= meta;
            // Any agreeing cycle restarts the qualification window
            if (o_sync != o_stable) begin
                if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    o_stable <= o_sync;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/display_link_sequencer.sv
// DVI bring-up/recovery sequencer: lock -> HPD -> timing reset hold -> blanked frames -> active.
module display_link_sequencer
    import display_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned RST_HOLD_CYCLES = 16,
    parameter int unsigned BLANK_FRAMES    = 2,
    parameter int unsigned CNT_W           = 20
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clk_lock,
    input  logic               i_hpd,
    input  logic               i_frame,
    output logic               o_timing_rst,
    output logic               o_blank,
    output logic               o_link_up,
    output logic [STATE_W-1:0] o_state
);

    logic             lock_s;
    logic             lock_db_unused;
    logic             hpd_s;
    logic             hpd_db;
    state_t           state_q;
    state_t           state_n;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] cnt_inc;

    sync_debounce #(
        .DEBOUNCE_CYCLES(1),
        .CNT_W          (1)
    ) u_lock_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_clk_lock),
        .o_sync  (lock_s),
        .o_stable(lock_db_unused)
    );

    sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_hpd_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_hpd),
        .o_sync  (hpd_s),
        .o_stable(hpd_db)
    );

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (lock_s) state_n = ST_WAIT_HPD;
            end
            ST_WAIT_HPD: begin
                if (hpd_db) begin
                    state_n = ST_RST_HOLD;
                    cnt_n   = '0;
                end
            end
            ST_RST_HOLD: begin
                if (cnt_q == CNT_W'(RST_HOLD_CYCLES - 1)) begin
                    state_n = ST_SYNC_FRAMES;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            ST_SYNC_FRAMES: begin
                if (i_frame) begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == CNT_W'(BLANK_FRAMES)) state_n = ST_ACTIVE;
                end
            end
            ST_ACTIVE: ;
            default: begin
                state_n = ST_WAIT_LOCK;
                cnt_n   = '0;
            end
        endcase

        // Teardown overrides the forward path; lock loss outranks unplug
        if (state_q != ST_WAIT_LOCK && !lock_s) begin
            state_n = ST_WAIT_LOCK;
            cnt_n   = '0;
        end else if (!hpd_db && (state_q == ST_RST_HOLD || state_q == ST_SYNC_FRAMES ||
                                 state_q == ST_ACTIVE)) begin
            state_n = ST_WAIT_HPD;
            cnt_n   = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_WAIT_LOCK;
            cnt_q        <= '0;
            o_timing_rst <= 1'b1;
            o_blank      <= 1'b1;
            o_link_up    <= 1'b0;
        end else begin
            state_q      <= state_n;
            cnt_q        <= cnt_n;
            o_timing_rst <= (state_n == ST_WAIT_LOCK) || (state_n == ST_WAIT_HPD) ||
                            (state_n == ST_RST_HOLD);
            o_blank      <= (state_n != ST_ACTIVE);
            o_link_up    <= (state_n == ST_ACTIVE);
        end
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_display_link_sequencer.sv
// Directed bench for display_link_sequencer with short debounce/hold/frame parameters.
module tb_display_link_sequencer;
    import display_pkg::*;

    logic               clk;
    logic               rst;
    logic               clk_lock;
    logic               hpd;
    logic               frame;
    logic               timing_rst;
    logic               blank;
    logic               link_up;
    logic [STATE_W-1:0] state;

    int unsigned n_cmp;
    int unsigned n_bad;

    display_link_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .RST_HOLD_CYCLES(3),
        .BLANK_FRAMES   (2),
        .CNT_W          (8)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_clk_lock  (clk_lock),
        .i_hpd       (hpd),
        .i_frame     (frame),
        .o_timing_rst(timing_rst),
        .o_blank     (blank),
        .o_link_up   (link_up),
        .o_state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic frame_pulse();
        frame = 1'b1;
        @(negedge clk);
        frame = 1'b0;
    endtask

    task automatic check_outs(input string tag, input state_t st, input logic trst,
                              input logic blk, input logic up);
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".trst"}, 32'(timing_rst), 32'(trst));
        check({tag, ".blank"}, 32'(blank), 32'(blk));
        check({tag, ".link"}, 32'(link_up), 32'(up));
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        clk_lock = 1'b1;
        hpd      = 1'b1;
        frame    = 1'b0;
        step(3);
        check_outs("reset", ST_WAIT_LOCK, 1'b1, 1'b1, 1'b0);

        // 1: clean bring-up, edges counted from the release negedge
        rst = 1'b0;
        step(2);
        check_outs("up.sync", ST_WAIT_LOCK, 1'b1, 1'b1, 1'b0);
        step(1);
        check_outs("up.hpd_wait", ST_WAIT_HPD, 1'b1, 1'b1, 1'b0);
        step(3);
        check("up.hpd_wait_end", 32'(state), 32'(ST_WAIT_HPD));
        step(1);
        check_outs("up.rst_hold", ST_RST_HOLD, 1'b1, 1'b1, 1'b0);
        step(2);
        check_outs("up.rst_hold_last", ST_RST_HOLD, 1'b1, 1'b1, 1'b0);
        step(1);
        check_outs("up.sync_frames", ST_SYNC_FRAMES, 1'b0, 1'b1, 1'b0);
        step(4);
        frame_pulse();
        check_outs("up.frame1", ST_SYNC_FRAMES, 1'b0, 1'b1, 1'b0);
        step(5);
        frame_pulse();
        check_outs("up.active", ST_ACTIVE, 1'b0, 1'b0, 1'b1);
        step(5);
        check("up.active_hold", 32'(state), 32'(ST_ACTIVE));

        // 3: unplug in ACTIVE
        hpd = 1'b0;
        step(6);
        check("unplug.still_active", 32'(state), 32'(ST_ACTIVE));
        step(1);
        check_outs("unplug.wait_hpd", ST_WAIT_HPD, 1'b1, 1'b1, 1'b0);

        // 2: 3-cycle HPD glitch must not qualify
        hpd = 1'b1;
        step(3);
        hpd = 1'b0;
        for (int unsigned i = 0; i < 10; i++) begin
            step(1);
            check("glitch.state", 32'(state), 32'(ST_WAIT_HPD));
            check("glitch.trst", 32'(timing_rst), 32'd1);
        end

        // Replug: full hold and sync sequence again
        hpd = 1'b1;
        step(6);
        check("replug.pre", 32'(state), 32'(ST_WAIT_HPD));
        step(1);
        check_outs("replug.rst_hold", ST_RST_HOLD, 1'b1, 1'b1, 1'b0);
        step(3);
        check_outs("replug.sync", ST_SYNC_FRAMES, 1'b0, 1'b1, 1'b0);

        // 4: lock loss during SYNC_FRAMES
        clk_lock = 1'b0;
        step(2);
        check("lockloss.pre", 32'(state), 32'(ST_SYNC_FRAMES));
        step(1);
        check_outs("lockloss.wait_lock", ST_WAIT_LOCK, 1'b1, 1'b1, 1'b0);
        clk_lock = 1'b1;
        step(3);
        check("relock.wait_hpd", 32'(state), 32'(ST_WAIT_HPD));
        step(1);
        check("relock.rst_hold", 32'(state), 32'(ST_RST_HOLD));
        step(3);
        check("relock.sync", 32'(state), 32'(ST_SYNC_FRAMES));
        frame_pulse();
        check("relock.frame1", 32'(state), 32'(ST_SYNC_FRAMES));
        step(2);
        frame_pulse();
        check_outs("relock.active", ST_ACTIVE, 1'b0, 1'b0, 1'b1);

        // 5a: lock_s and hpd_db fall on the same cycle in ACTIVE
        hpd = 1'b0;
        step(4);
        clk_lock = 1'b0;
        step(2);
        check("simul.pre", 32'(state), 32'(ST_ACTIVE));
        step(1);
        check_outs("simul.wait_lock", ST_WAIT_LOCK, 1'b1, 1'b1, 1'b0);

        clk_lock = 1'b1;
        hpd      = 1'b1;
        step(7);
        check("simul.recover_hold", 32'(state), 32'(ST_RST_HOLD));
        step(3);
        check("simul.recover_sync", 32'(state), 32'(ST_SYNC_FRAMES));

        // 5b: final frame coincides with the debounced unplug
        frame_pulse();
        hpd = 1'b0;
        step(6);
        check("lastframe.pre", 32'(state), 32'(ST_SYNC_FRAMES));
        frame_pulse();
        check_outs("lastframe.wait_hpd", ST_WAIT_HPD, 1'b1, 1'b1, 1'b0);

        // 6: async reset in the middle of RST_HOLD
        hpd = 1'b1;
        step(8);
        check("arst.in_hold", 32'(state), 32'(ST_RST_HOLD));
        #2 rst = 1'b1;
        #1;
        check_outs("arst.immediate", ST_WAIT_LOCK, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step(3);
        check("arst.restart", 32'(state), 32'(ST_WAIT_HPD));
        step(4);
        check("arst.rst_hold", 32'(state), 32'(ST_RST_HOLD));
        frame_pulse();
        check("arst.frame_ignored", 32'(state), 32'(ST_RST_HOLD));
        step(2);
        check("arst.sync", 32'(state), 32'(ST_SYNC_FRAMES));
        frame_pulse();
        check("arst.frame1", 32'(state), 32'(ST_SYNC_FRAMES));
        step(1);
        frame_pulse();
        check_outs("arst.active", ST_ACTIVE, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
